emulador_hcsr04: RTL
====================

# emulador_hcsr04

Synthesizable responder model of an HC-SR04 ultrasonic sensor: it receives the `trigger` pulse produced by the sonar and answers with an `echo` pulse whose width encodes a programmable distance in centimetres. It sits on the sensor side of the trigger/echo interface. It is used on the FPGA (echo pin looped to the sonar) and in benches in place of hand-timed echo stimulus. Nominal clock is 50 MHz; all timing below is in clock cycles.

## Interface
- `TRIG_MIN_CYCLES`, 500: minimum synchronized trigger high time accepted (10 us).
- `ECHO_DELAY_CYCLES`, 1000: trigger falling edge to echo rise (20 us).
- `CYCLES_PER_CM`, 2941: echo cycles per centimetre (58.82 us/cm).
- `MAX_CM`, 400: largest valid distance.
- `TIMEOUT_CYCLES`, 1_900_000: echo width for out-of-range distance (38 ms).
- `HOLDOFF_CYCLES`, 50_000: dead time after echo during which triggers are ignored (1 ms).

Ports:
- `clock` in 1: system clock. One clock domain; no other clock in the block.
- `reset` in 1: asynchronous, active-high reset.
- `habilitar` in 1: responder enable; low forces `INICIAL`.
- `trigger` in 1: asynchronous trigger from the sonar.
- `distancia` in 9: simulated distance in cm, unsigned binary.
- `echo` out 1: echo pulse, registered.
- `ocupado` out 1: high in every state except `INICIAL` and `ESPERA_TRIGGER`.
- `pronto` out 1: one-cycle pulse on the cycle `echo` falls.
- `db_estado` out 4: current state code.

## Operation
- `trigger` passes through a 2-flop synchronizer to produce `trig_s`. Edge detection is done on `trig_s` against its previous value.
- States and codes:
  - `INICIAL` (0): idle. Goes to `ESPERA_TRIGGER` when `habilitar`=1.
  - `ESPERA_TRIGGER` (1): waits for a rising edge of `trig_s`, then goes to `MEDE_TRIGGER` with the width counter cleared.
  - `MEDE_TRIGGER` (2): counts cycles while `trig_s`=1. When `trig_s`=0:
    - if count >= `TRIG_MIN_CYCLES`: latch `distancia` and go to `ESPERA_ECHO`.
    - otherwise: go back to `ESPERA_TRIGGER`. No echo is produced.
  - `ESPERA_ECHO` (3): stays exactly `ECHO_DELAY_CYCLES` cycles, then goes to `ECHO_ALTO`.
  - `ECHO_ALTO` (4): `echo`=1. Width rules:
    - latched distance d in 1..`MAX_CM`: width is exactly d*`CYCLES_PER_CM` cycles.
    - d=0 or d>`MAX_CM`: width is `TIMEOUT_CYCLES`.
    - Width is generated by a cycle counter (0..`CYCLES_PER_CM`-1) plus a cm counter; no multiplier. The counters are sized for `TIMEOUT_CYCLES` and for 511*`CYCLES_PER_CM` without overflow.
  - `HOLDOFF` (5): `echo`=0 for `HOLDOFF_CYCLES` cycles, then goes to `ESPERA_TRIGGER`.
- Trigger activity in `ESPERA_ECHO`, `ECHO_ALTO` and `HOLDOFF` is ignored.
- If `trig_s` is still high on entry to `ESPERA_TRIGGER`, a fresh rising edge is required before a new measurement starts.
- Changes on `distancia` after the latch do not affect the echo in progress.
- `habilitar`=0 in any state: next state is `INICIAL`, `echo` drops on the next edge, and `pronto` is not pulsed.
- Unused state codes go to `INICIAL`.

## Timing
- Reset values: `echo`=0, `ocupado`=0, `pronto`=0, `db_estado`=0, state `INICIAL`, all counters 0, synchronizer flops 0.
- Reset asserted mid-operation: `echo` drops asynchronously with no `pronto`. Operation resumes from `INICIAL`.
- Trigger acceptance latency: `trig_s` lags `trigger` by 2 cycles. A trigger of exactly `TRIG_MIN_CYCLES` cycles is accepted; `TRIG_MIN_CYCLES`-1 cycles is rejected.
- Echo rise: exactly `ECHO_DELAY_CYCLES`+1 cycles after the cycle `MEDE_TRIGGER` sees `trig_s`=0.
- `pronto`: high for exactly the one cycle in which `echo` first reads 0 after `ECHO_ALTO`. It coincides with entry to `HOLDOFF`.
- Next accepted trigger rising edge: at least `HOLDOFF_CYCLES` cycles after `pronto`.

## Test plan
- Reset for 10 cycles, `habilitar`=1, `distancia`=100, 10 us trigger -> echo rises about 20 us after trigger fall and lasts 294_100 cycles (5882 us); `pronto` pulses once; `db_estado` goes 1,2,3,4,5,1.
- `distancia`=170, 12 us trigger -> echo width 499_970 cycles. `distancia` changed to 5 during the echo -> width unchanged.
- Trigger of 499 cycles -> no echo, state returns to 1. Trigger of 500 cycles -> echo for `distancia`=1 is 2941 cycles.
- `distancia`=0 and `distancia`=450 -> echo width 1_900_000 cycles each.
- Second trigger sent during `ECHO_ALTO` and again 500 us into `HOLDOFF` -> both ignored. Trigger sent 1.1 ms after `pronto` -> new echo.
- `reset` pulsed mid-echo -> `echo`=0 within the same cycle, no `pronto`, `db_estado`=0. `habilitar` dropped mid-echo -> `echo`=0 next edge, `db_estado`=0.

Source files
------------

// File: rtl/emulador_hcsr04.sv
// emulador_hcsr04: sensor-side model of an HC-SR04 ultrasonic ranger.
// It measures the width of the trigger pulse from the sonar. After a valid
// trigger it waits a fixed delay, then drives an echo pulse whose width
// encodes the distance latched at the end of the trigger. A hold-off period
// follows each echo, and triggers are ignored until it has elapsed.
module emulador_hcsr04 #(
   parameter int unsigned TRIG_MIN_CYCLES   = 500,
   parameter int unsigned ECHO_DELAY_CYCLES = 1000,
   parameter int unsigned CYCLES_PER_CM     = 2941,
   parameter int unsigned MAX_CM            = 400,
   parameter int unsigned TIMEOUT_CYCLES    = 1_900_000,
   parameter int unsigned HOLDOFF_CYCLES    = 50_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilitar,
   input  logic       trigger,
   input  logic [8:0] distancia,
   output logic       echo,
   output logic       ocupado,
   output logic       pronto,
   output logic [3:0] db_estado
);

   // One shared counter serves the trigger width, the echo delay, the timeout
   // width and the hold-off. Its width is set by the longest of these spans.
   localparam int unsigned SPAN_A = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
   localparam int unsigned SPAN_B = (ECHO_DELAY_CYCLES > TRIG_MIN_CYCLES) ? ECHO_DELAY_CYCLES : TRIG_MIN_CYCLES;
   localparam int unsigned SPAN   = (SPAN_A > SPAN_B) ? SPAN_A : SPAN_B;
   localparam int CNT_W = $clog2(SPAN + 1);
   localparam int CYC_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

   // The rising-edge cycle of trig_s is consumed in ESPERA_TRIGGER. The count
   // therefore holds (high width - 1) when the trigger falls.
   localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_MIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(ECHO_DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CYC_W-1:0] CYC_LAST     = CYC_W'(CYCLES_PER_CM - 1);
   localparam logic [8:0]       MAX_CM_V     = 9'(MAX_CM);

   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      ESPERA_TRIGGER = 4'd1,
      MEDE_TRIGGER   = 4'd2,
      ESPERA_ECHO    = 4'd3,
      ECHO_ALTO      = 4'd4,
      HOLDOFF        = 4'd5
   } estado_t;

   estado_t          estado_q, estado_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [8:0]       cm_q, cm_d;
   logic [8:0]       dist_q, dist_d;
   logic             fora_q, fora_d;
   logic             echo_q, echo_d;
   logic             ocupado_q, ocupado_d;
   logic             pronto_q, pronto_d;
   logic             sync1_q, trig_s_q, trig_prev_q;
   logic             trig_rise;
   logic             fim_echo;

   assign trig_rise = trig_s_q & ~trig_prev_q;

   // Next-state, counter and output computation for the responder FSM
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
      estado_d = estado_q;
      cnt_d    = cnt_q;
      cyc_d    = cyc_q;
      cm_d     = cm_q;
      dist_d   = dist_q;
      fora_d   = fora_q;
      fim_echo = 1'b0;

      if (!habilitar) begin
         estado_d = INICIAL;
         cnt_d    = '0;
      end else begin
         case (estado_q)
            INICIAL: begin
               estado_d = ESPERA_TRIGGER;
               cnt_d    = '0;
            end
            ESPERA_TRIGGER: begin
               if (trig_rise) begin
                  estado_d = MEDE_TRIGGER;
                  cnt_d    = '0;
               end
            end
            MEDE_TRIGGER: begin
               if (trig_s_q) begin
                  // Saturate at the threshold so a trigger held very long
                  // cannot wrap the counter and be rejected.
                  if (cnt_q != TRIG_LAST) cnt_d = cnt_q + 1'b1;
               end else if (cnt_q == TRIG_LAST) begin
                  estado_d = ESPERA_ECHO;
                  cnt_d    = '0;
                  dist_d   = distancia;
                  fora_d   = (distancia == 9'd0) || (distancia > MAX_CM_V);
               end else begin
                  estado_d = ESPERA_TRIGGER;
               end
            end
            ESPERA_ECHO: begin
               if (cnt_q == DELAY_LAST) begin
                  estado_d = ECHO_ALTO;
                  cnt_d    = '0;
                  cyc_d    = '0;
                  cm_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ECHO_ALTO: begin
               if (fora_q) begin
                  if (cnt_q == TIMEOUT_LAST) fim_echo = 1'b1;
                  else                       cnt_d    = cnt_q + 1'b1;
               end else if (cyc_q == CYC_LAST) begin
                  // One centimetre has elapsed. Stop after the latched count.
                  cyc_d = '0;
                  if (cm_q == dist_q - 9'd1) fim_echo = 1'b1;
                  else                       cm_d     = cm_q + 9'd1;
               end else begin
                  cyc_d = cyc_q + 1'b1;
               end
               if (fim_echo) begin
                  estado_d = HOLDOFF;
                  cnt_d    = '0;
               end
            end
            HOLDOFF: begin
               if (cnt_q == HOLD_LAST) begin
                  estado_d = ESPERA_TRIGGER;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: estado_d = INICIAL;
         endcase
      end

      // Outputs are derived from the next state so that they register in step with it
      echo_d    = (estado_d == ECHO_ALTO);
      ocupado_d = !((estado_d == INICIAL) || (estado_d == ESPERA_TRIGGER));
      pronto_d  = (estado_q == ECHO_ALTO) && (estado_d == HOLDOFF);
   end

   // State, counters, synchronizer and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q    <= INICIAL;
         cnt_q       <= '0;
         cyc_q       <= '0;
         cm_q        <= '0;
         dist_q      <= '0;
         fora_q      <= 1'b0;
         echo_q      <= 1'b0;
         ocupado_q   <= 1'b0;
         pronto_q    <= 1'b0;
         sync1_q     <= 1'b0;
         trig_s_q    <= 1'b0;
         trig_prev_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample pre-edge values, so the synchronizer chain shifts by exactly one stage per clock.
         estado_q    <= estado_d;
         cnt_q       <= cnt_d;
         cyc_q       <= cyc_d;
         cm_q        <= cm_d;
         dist_q      <= dist_d;
         fora_q      <= fora_d;
         echo_q      <= echo_d;
         ocupado_q   <= ocupado_d;
         pronto_q    <= pronto_d;
         sync1_q     <= trigger;
         trig_s_q    <= sync1_q;
         trig_prev_q <= trig_s_q;
      end
   end

   assign echo      = echo_q;
   assign ocupado   = ocupado_q;
   assign pronto    = pronto_q;
   assign db_estado = estado_q;

endmodule
